// File: rtl/left_rotate_seq.sv
// Multi-cycle left rotator / logical left shifter, one power-of-two stage per clock.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_cnt/in_mode, out_valid/out_ready/out_data/out_zero.
module left_rotate_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam int STG_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mode_q;
    logic [STG_W-1:0]   stage_q;
    logic               last_stage;

    // Per-stage candidates: rotate or zero-fill shift by 2**g.
    logic [WIDTH-1:0]   rol_s [CNT_W];
    logic [WIDTH-1:0]   sll_s [CNT_W];

    for (genvar g = 0; g < CNT_W; g++) begin : g_stage
        localparam int SH = 1 << g;
        assign rol_s[g] = {data_q[WIDTH-SH-1:0], data_q[WIDTH-1:WIDTH-SH]};
        assign sll_s[g] = {data_q[WIDTH-SH-1:0], {SH{1'b0}}};
    end

    assign last_stage = (stage_q == STG_W'(CNT_W - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_stage) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            stage_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        cnt_q   <= in_cnt;
                        mode_q  <= in_mode;
                        stage_q <= '0;
                    end
                end
                RUN: begin
                    if (cnt_q[stage_q]) begin
                        data_q <= mode_q ? sll_s[stage_q] : rol_s[stage_q];
                    end
                    stage_q <= stage_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    // Gated so reset (data_q == 0) does not report a zero result.
    assign out_zero  = out_valid && (data_q == '0);

endmodule

// File: tb/tb_left_rotate_seq.sv
// Self-checking bench for left_rotate_seq: directed cases plus random traffic.
// A cycle-level behavioural model predicts handshakes and results.
module tb_left_rotate_seq;

    localparam int W   = 16;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [CW-1:0] in_cnt;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    left_rotate_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] f_rol(input logic [15:0] x, input int k);
        int v;
        v = int'(x);
        return 16'(((v << k) | (v >> (16 - k))) & 32'hFFFF);
    endfunction

    function automatic logic [15:0] f_ror(input logic [15:0] x, input int k);
        int v;
        v = int'(x);
        return 16'(((v >> k) | (v << (16 - k))) & 32'hFFFF);
    endfunction

    function automatic logic [15:0] f_sll(input logic [15:0] x, input int k);
        int v;
        v = int'(x);
        return 16'((v << k) & 32'hFFFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 busy (counts down the fixed latency), 2 result held.
    int            m_ph;
    int            m_wait;
    logic [15:0]   m_x;
    int            m_k;
    logic          m_md;
    logic [15:0]   m_res;
    int            n_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph   <= 0;
            m_wait <= 0;
        end else begin
            case (m_ph)
                0: if (in_valid) begin
                    m_x    <= in_data;
                    m_k    <= int'(in_cnt);
                    m_md   <= in_mode;
                    m_res  <= in_mode ? f_sll(in_data, int'(in_cnt))
                                      : f_rol(in_data, int'(in_cnt));
                    m_wait <= CW;
                    m_ph   <= 1;
                    n_acc  <= n_acc + 1;
                end
                1: begin
                    m_wait <= m_wait - 1;
                    if (m_wait == 1) m_ph <= 2;
                end
                default: if (out_ready) m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_ph == 0));
            chk("out_valid", 32'(out_valid), 32'(m_ph == 2));
            if (m_ph == 2 && out_valid) begin
                chk("out_data", 32'(out_data), 32'(m_res));
                chk("out_zero", 32'(out_zero), 32'(m_res == 16'h0));
                if (!m_md) begin
                    chk("ror_back", 32'(f_ror(out_data, m_k)), 32'(m_x));
                end
            end
        end
    end

    task automatic req(input logic [15:0] d, input logic [3:0] c, input logic m,
                       input logic [15:0] exp, input int hold);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_cnt    = c;
        in_mode   = m;
        out_ready = 1'b0;
        @(negedge clk);
        // Garbage request held during RUN/DONE must be ignored.
        in_data = 16'hFFFF;
        in_cnt  = 4'd7;
        in_mode = ~m;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd5);
        chk("dir_data", 32'(out_data), 32'(exp));
        chk("dir_zero", 32'(out_zero), 32'(exp == 16'h0));
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(exp));
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("back_idle", 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cnt    = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        n_acc     = 0;
        cmp_en    = 1'b1;

        repeat (4) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            in_data   = 16'($urandom);
            in_cnt    = 4'($urandom);
            in_mode   = 1'($urandom);
            out_ready = 1'($urandom);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
            chk("rst_out_zero", 32'(out_zero), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 rst_n = 1'b1;

        chk("pin_rol1", 32'(f_rol(16'h8001, 1)), 32'h0003);
        chk("pin_rol15", 32'(f_rol(16'h0001, 15)), 32'h8000);
        chk("pin_sll4", 32'(f_sll(16'hFFFF, 4)), 32'hFFF0);
        chk("pin_ror3", 32'(f_ror(16'h0008, 3)), 32'h0001);

        req(16'h8001, 4'd1,  1'b0, 16'h0003, 0);
        req(16'h0001, 4'd15, 1'b0, 16'h8000, 0);
        req(16'hFFFF, 4'd4,  1'b1, 16'hFFF0, 0);
        req(16'h8000, 4'd1,  1'b1, 16'h0000, 0);
        req(16'h1234, 4'd0,  1'b0, 16'h1234, 0);
        req(16'hA5A5, 4'd8,  1'b0, 16'hA5A5, 3);
        req(16'h00F0, 4'd4,  1'b0, 16'h0F00, 1);

        // Abort in RUN after two stages have been applied.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_cnt   = 4'd3;
        in_mode  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_data", 32'(out_data), 32'd0);
        #1 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        req(16'h0001, 4'd3, 1'b1, 16'h0008, 0);

        cyc = 0;
        n_acc = 0;
        while (n_acc < 1000 && cyc < 60000) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = 16'($urandom);
            in_cnt    = 4'($urandom);
            in_mode   = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            cyc++;
        end
        chk("rand_accepts", 32'(n_acc >= 1000), 32'd1);

        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
